// File: rtl/apb_gpio_master_arb_pkg.sv
`default_nettype none
// ============================================================================
// apb_gpio_master_arb_pkg : FSM encodings and gpio_apb register offsets
// Revision: 1.0
// ============================================================================
package apb_gpio_master_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam logic [31:0] GPIO_REG_DATA_IN  = 32'h0000_0000;
    localparam logic [31:0] GPIO_REG_DATA_OUT = 32'h0000_0004;
    localparam logic [31:0] GPIO_REG_DIR      = 32'h0000_0008;
    localparam logic [31:0] GPIO_REG_IRQ      = 32'h0000_000C;
    localparam logic [31:0] GPIO_REG_LIMIT    = 32'h0000_0010;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arb2.sv
`default_nettype none
// ============================================================================
// apb_rr_arb2 : combinational two-way round-robin grant
// Revision: 1.0
// ============================================================================
module apb_rr_arb2 (
    input  logic [1:0] req_valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o
);

    // A lone requester always wins; rr_ptr only breaks ties.
    assign grant_o[0] = req_valid_i[0] & (~req_valid_i[1] | ~rr_ptr_i);
    assign grant_o[1] = req_valid_i[1] & (~req_valid_i[0] |  rr_ptr_i);

endmodule
`default_nettype wire

// File: rtl/apb_gpio_master_arb.sv
`default_nettype none
// ============================================================================
// apb_gpio_master_arb : two-requester APB3 master with round-robin and timeout
// Revision: 1.0
// ============================================================================
module apb_gpio_master_arb
    import apb_gpio_master_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_e           state_q;
    logic             rr_ptr_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       grant;
    logic             sel;
    logic             timeout_hit;

    apb_rr_arb2 u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant)
    );

    assign req_ready   = (state_q == ST_IDLE && !PRESET) ? grant : 2'b00;
    assign sel         = grant[1];
    assign cnt_d       = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_LIMIT);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_q <= sel;
                        PWRITE  <= req_write[sel];
                        PADDR   <= sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
                        PWDATA  <= sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : req_wdata[DATA_WIDTH-1:0];
                        PSEL    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A real PREADY beats a timeout landing in the same cycle.
                    if (PREADY || timeout_hit) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= owner_q ? 2'b10 : 2'b01;
                        rsp_err   <= PREADY ? PSLVERR : 1'b1;
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                        rr_ptr_q  <= ~owner_q;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
